// File: rtl/bpsk_pkg.sv
// Shared constants, types and the bit-to-symbol mapper for the BPSK transmit path.
package bpsk_pkg;

    localparam int unsigned HAM_N = 12;
    localparam int unsigned BCH_N = 15;
    localparam int unsigned BIT_W = $clog2(BCH_N + 1);

    localparam logic [1:0] SYM_POS  = 2'b01;
    localparam logic [1:0] SYM_NEG  = 2'b11;
    localparam logic [1:0] SYM_IDLE = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    // Codeword selected for transmission, already widened to the BCH length.
    typedef struct packed {
        logic [BCH_N-1:0] word;
        logic [BIT_W-1:0] len;
        logic             src;
    } frame_t;

    function automatic logic [1:0] bpsk_map(input logic b);
        return b ? SYM_NEG : SYM_POS;
    endfunction

endpackage

// File: rtl/bpsk_tx_scheduler_if.sv
// Encoder-side handshakes and symbol-side outputs of the BPSK transmit scheduler.
interface bpsk_tx_scheduler_if;
    import bpsk_pkg::*;

    logic             ham_valid;
    logic [HAM_N-1:0] ham_data;
    logic             ham_ready;
    logic             bch_valid;
    logic [BCH_N-1:0] bch_data;
    logic             bch_ready;
    logic [1:0]       sym_out;
    logic             sym_valid;
    logic             sym_strobe;
    logic             sym_last;
    logic             src_id;
    logic             busy;

    modport master (
        output ham_valid, ham_data, bch_valid, bch_data,
        input  ham_ready, bch_ready, sym_out, sym_valid, sym_strobe, sym_last, src_id, busy
    );

    modport slave (
        input  ham_valid, ham_data, bch_valid, bch_data,
        output ham_ready, bch_ready, sym_out, sym_valid, sym_strobe, sym_last, src_id, busy
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a lone request wins, a tie goes to the side not served last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_grant
);

    logic r_prio;  // 0 favours requester 0, 1 favours requester 1

    always_comb begin
        o_grant = i_req;
        if (i_req == 2'b11) begin
            o_grant = r_prio ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (i_update) begin
            r_prio <= o_grant[0];
        end
    end

endmodule

// File: rtl/bpsk_tx_scheduler.sv
// Round-robin scheduler that serialises Hamming/BCH codewords LSB-first into BPSK
// symbols, each held for SPS clocks.
module bpsk_tx_scheduler #(
    parameter int unsigned SPS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bpsk_tx_scheduler_if.slave   bus
);
    import bpsk_pkg::*;

    localparam int unsigned      SMP_W    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SPS - 1);
    localparam logic [BIT_W-1:0] LEN_HAM  = BIT_W'(HAM_N);
    localparam logic [BIT_W-1:0] LEN_BCH  = BIT_W'(BCH_N);

    state_t           r_state;
    logic [BCH_N-2:0] r_shreg;     // bits still to send after the current symbol
    logic [BIT_W-1:0] r_len;
    logic [BIT_W-1:0] r_bit_cnt;
    logic [SMP_W-1:0] r_smp_cnt;
    logic             r_src;
    logic [1:0]       r_sym_out;
    logic             r_sym_valid;
    logic             r_sym_strobe;
    logic             r_sym_last;
    logic             r_busy;

    logic             w_idle;
    logic [1:0]       w_grant;
    logic             w_accept;
    frame_t           w_frame;

    // Ready is forced low while reset is asserted so no grant leaks out of reset.
    assign w_idle = (r_state == IDLE) && rst_n;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    ({bus.bch_valid, bus.ham_valid}),
        .i_update (w_accept),
        .o_grant  (w_grant)
    );

    assign bus.ham_ready = w_idle & w_grant[0];
    assign bus.bch_ready = w_idle & w_grant[1];
    assign w_accept      = bus.ham_ready | bus.bch_ready;

    always_comb begin
        w_frame = '{word: BCH_N'(bus.ham_data), len: LEN_HAM, src: 1'b0};
        if (w_grant[1]) begin
            w_frame = '{word: bus.bch_data, len: LEN_BCH, src: 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_len        <= '0;
            r_bit_cnt    <= '0;
            r_smp_cnt    <= '0;
            r_src        <= 1'b0;
            r_sym_out    <= SYM_IDLE;
            r_sym_valid  <= 1'b0;
            r_sym_strobe <= 1'b0;
            r_sym_last   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state      <= SEND;
                        r_shreg      <= w_frame.word[BCH_N-1:1];
                        r_len        <= w_frame.len;
                        r_src        <= w_frame.src;
                        r_bit_cnt    <= '0;
                        r_smp_cnt    <= '0;
                        r_sym_out    <= bpsk_map(w_frame.word[0]);
                        r_sym_valid  <= 1'b1;
                        r_sym_strobe <= 1'b1;
                        r_sym_last   <= 1'b0;
                        r_busy       <= 1'b1;
                    end
                end
                SEND: begin
                    if (r_smp_cnt != SMP_LAST) begin
                        r_smp_cnt    <= r_smp_cnt + SMP_W'(1);
                        r_sym_strobe <= 1'b0;
                    end else if (r_bit_cnt == r_len - BIT_W'(1)) begin
                        r_state      <= IDLE;
                        r_shreg      <= '0;
                        r_bit_cnt    <= '0;
                        r_smp_cnt    <= '0;
                        r_sym_out    <= SYM_IDLE;
                        r_sym_valid  <= 1'b0;
                        r_sym_strobe <= 1'b0;
                        r_sym_last   <= 1'b0;
                        r_busy       <= 1'b0;
                    end else begin
                        r_shreg      <= r_shreg >> 1;
                        r_bit_cnt    <= r_bit_cnt + BIT_W'(1);
                        r_smp_cnt    <= '0;
                        r_sym_out    <= bpsk_map(r_shreg[0]);
                        r_sym_strobe <= 1'b1;
                        r_sym_last   <= (r_bit_cnt + BIT_W'(1)) == (r_len - BIT_W'(1));
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.sym_out    = r_sym_out;
    assign bus.sym_valid  = r_sym_valid;
    assign bus.sym_strobe = r_sym_strobe;
    assign bus.sym_last   = r_sym_last;
    assign bus.src_id     = r_src;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Bench for bpsk_tx_scheduler: SPS=4 and SPS=1 instances share stimulus and are
// checked every cycle against a frame-level model, plus hand-computed expectations.
module tb_bpsk_tx_scheduler;
    import bpsk_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ham_valid;
    logic [HAM_N-1:0] ham_data;
    logic             bch_valid;
    logic [BCH_N-1:0] bch_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bpsk_tx_scheduler_if ifc0 ();
    bpsk_tx_scheduler_if ifc1 ();

    assign ifc0.ham_valid = ham_valid;
    assign ifc0.ham_data  = ham_data;
    assign ifc0.bch_valid = bch_valid;
    assign ifc0.bch_data  = bch_data;
    assign ifc1.ham_valid = ham_valid;
    assign ifc1.ham_data  = ham_data;
    assign ifc1.bch_valid = bch_valid;
    assign ifc1.bch_data  = bch_data;

    bpsk_tx_scheduler #(.SPS(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0.slave));
    bpsk_tx_scheduler #(.SPS(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1.slave));

    // Frame-level model: per instance, the frame in flight and the clock index within it.
    bit               m_busy [2];
    logic [BCH_N-1:0] m_word [2];
    int               m_len  [2];
    bit               m_src  [2];
    int               m_t    [2];
    bit               m_prio [2];   // 1 when BCH wins the next tie
    int               acc_src0 [$];

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    task automatic model_inst(input int g, input logic hr, input logic br, input logic [1:0] so,
                              input logic sv, input logic ss, input logic sl, input logic sid,
                              input logic bz);
        string p;
        int    n;
        int    sym_idx;
        logic  e_hr, e_br, e_sv, e_ss, e_sl, e_bz;
        logic [1:0] e_so;
        p = (g == 0) ? "sps4" : "sps1";
        n = (g == 0) ? 4 : 1;
        e_hr = 0; e_br = 0; e_sv = 0; e_ss = 0; e_sl = 0; e_bz = 0; e_so = 2'b00;
        if (!rst_n) begin
            m_busy[g] = 0; m_prio[g] = 0; m_src[g] = 0; m_t[g] = 0;
            chk({p, ".src_id"}, int'(sid), 0);
        end else if (m_busy[g]) begin
            sym_idx = m_t[g] / n;
            e_so = m_word[g][sym_idx] ? 2'b11 : 2'b01;
            e_sv = 1; e_bz = 1;
            e_ss = (m_t[g] % n) == 0;
            e_sl = (sym_idx == m_len[g] - 1);
            chk({p, ".src_id"}, int'(sid), int'(m_src[g]));
            m_t[g]++;
            if (m_t[g] == m_len[g] * n) m_busy[g] = 0;
        end else begin
            if (ham_valid && bch_valid) begin
                e_hr = !m_prio[g];
                e_br = m_prio[g];
            end else begin
                e_hr = ham_valid;
                e_br = bch_valid;
            end
            if (e_hr) begin
                m_word[g] = BCH_N'(ham_data); m_len[g] = HAM_N; m_src[g] = 0; m_prio[g] = 1;
            end
            if (e_br) begin
                m_word[g] = bch_data; m_len[g] = BCH_N; m_src[g] = 1; m_prio[g] = 0;
            end
            if (e_hr || e_br) begin
                m_busy[g] = 1;
                m_t[g] = 0;
                if (g == 0) acc_src0.push_back(e_br ? 1 : 0);
            end
        end
        chk({p, ".ham_ready"},  int'(hr), int'(e_hr));
        chk({p, ".bch_ready"},  int'(br), int'(e_br));
        chk({p, ".sym_out"},    int'(so), int'(e_so));
        chk({p, ".sym_valid"},  int'(sv), int'(e_sv));
        chk({p, ".sym_strobe"}, int'(ss), int'(e_ss));
        chk({p, ".sym_last"},   int'(sl), int'(e_sl));
        chk({p, ".busy"},       int'(bz), int'(e_bz));
    endtask

    // Sample mid-cycle and step the model; inputs only change just after a rising edge.
    task automatic smp();
        @(negedge clk);
        model_inst(0, ifc0.ham_ready, ifc0.bch_ready, ifc0.sym_out, ifc0.sym_valid,
                   ifc0.sym_strobe, ifc0.sym_last, ifc0.src_id, ifc0.busy);
        model_inst(1, ifc1.ham_ready, ifc1.bch_ready, ifc1.sym_out, ifc1.sym_valid,
                   ifc1.sym_strobe, ifc1.sym_last, ifc1.src_id, ifc1.busy);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        smp();
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".sps4_out"}, int'({ifc0.ham_ready, ifc0.bch_ready, ifc0.sym_out, ifc0.sym_valid,
                                      ifc0.sym_strobe, ifc0.sym_last, ifc0.src_id, ifc0.busy}), 0);
        chk({tag, ".sps1_out"}, int'({ifc1.ham_ready, ifc1.bch_ready, ifc1.sym_out, ifc1.sym_valid,
                                      ifc1.sym_strobe, ifc1.sym_last, ifc1.src_id, ifc1.busy}), 0);
    endtask

    initial begin
        int   n_busy;
        bit   got;
        bit   found;
        logic prev;

        rst_n = 0; ham_valid = 0; bch_valid = 0; ham_data = '0; bch_data = '0;
        tick();
        chk_all_zero("reset");
        repeat (3) cyc();
        rst_n = 1;
        cyc();

        // Hamming 12'h001 at SPS=4: one -1 symbol then eleven +1 symbols.
        ham_valid = 1; ham_data = 12'h001;
        smp();
        chk("t1.ham_ready", int'(ifc0.ham_ready), 1);
        tick();
        ham_valid = 0; ham_data = HAM_N'($urandom);
        for (int k = 1; k <= 49; k++) begin
            smp();
            if (k == 1)  chk("t1.sym_k1", int'(ifc0.sym_out), 3);
            if (k == 4)  chk("t1.sym_k4", int'(ifc0.sym_out), 3);
            if (k == 5)  chk("t1.sym_k5", int'(ifc0.sym_out), 1);
            if (k == 44) chk("t1.last_k44", int'(ifc0.sym_last), 0);
            if (k == 45) chk("t1.last_k45", int'(ifc0.sym_last), 1);
            if (k == 48) chk("t1.last_k48", int'(ifc0.sym_last), 1);
            if (k == 49) chk("t1.busy_k49", int'(ifc0.busy), 0);
            tick();
        end

        // BCH 15'h4000: fourteen +1 symbols, then -1 with sym_last, 60 clocks.
        bch_valid = 1; bch_data = 15'h4000;
        smp();
        chk("t2.bch_ready", int'(ifc0.bch_ready), 1);
        tick();
        bch_valid = 0; bch_data = BCH_N'($urandom);
        n_busy = 0;
        for (int k = 1; k <= 61; k++) begin
            smp();
            n_busy += int'(ifc0.busy);
            if (k == 1)  chk("t2.src_k1", int'(ifc0.src_id), 1);
            if (k == 56) chk("t2.sym_k56", int'(ifc0.sym_out), 1);
            if (k == 57) chk("t2.sym_k57", int'(ifc0.sym_out), 3);
            if (k == 57) chk("t2.last_k57", int'(ifc0.sym_last), 1);
            if (k == 60) chk("t2.src_k60", int'(ifc0.src_id), 1);
            tick();
        end
        chk("t2.frame_clks", n_busy, 60);

        // SPS=1 with 12'hAAA: +1/-1 alternating every clock, strobe every clock.
        ham_valid = 1; ham_data = 12'hAAA;
        cyc();
        ham_valid = 0;
        for (int k = 1; k <= 49; k++) begin
            smp();
            if (k <= 12) chk("t5.sym", int'(ifc1.sym_out), (k % 2 == 1) ? 1 : 3);
            if (k <= 12) chk("t5.strobe", int'(ifc1.sym_strobe), 1);
            if (k == 13) chk("t5.busy_end", int'(ifc1.busy), 0);
            tick();
        end

        // Hamming valid pulsed during SEND is ignored, then held until accepted.
        bch_valid = 1; bch_data = BCH_N'($urandom);
        cyc();
        bch_valid = 0;
        repeat (10) cyc();
        ham_valid = 1;
        for (int k = 0; k < 3; k++) begin
            smp();
            chk("t6.no_ready", int'(ifc0.ham_ready), 0);
            tick();
        end
        ham_valid = 0;
        repeat (5) cyc();
        ham_valid = 1; ham_data = HAM_N'($urandom);
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            smp();
            got = ifc0.ham_ready;
            tick();
        end
        ham_valid = 0;
        chk("t6.accepted", int'(got), 1);
        repeat (70) cyc();

        // Both valid continuously from reset: Ham, BCH, Ham, BCH.
        rst_n = 0;
        repeat (2) cyc();
        rst_n = 1;
        acc_src0.delete();
        ham_valid = 1; bch_valid = 1;
        for (int k = 0; k < 240; k++) begin
            ham_data = HAM_N'($urandom); bch_data = BCH_N'($urandom);
            cyc();
        end
        chk("t3.n_grants_ge4", int'(acc_src0.size() >= 4), 1);
        for (int i = 0; i < 4 && i < acc_src0.size(); i++) chk("t3.grant_src", acc_src0[i], i % 2);

        // Reset in clock 20 of a BCH frame, then Hamming wins the next tie.
        found = 0; prev = 1;
        for (int i = 0; i < 300 && !found; i++) begin
            smp();
            if (ifc0.busy && ifc0.src_id && !prev) found = 1;
            prev = ifc0.busy;
            tick();
        end
        chk("t4.bch_frame_seen", int'(found), 1);
        repeat (18) cyc();
        #2 rst_n = 0;
        #1 chk_all_zero("t4.async");
        cyc();
        cyc();
        rst_n = 1;
        smp();
        chk("t4.ham_first", int'(ifc0.ham_ready), 1);
        chk("t4.bch_not", int'(ifc0.bch_ready), 0);
        tick();

        // Random traffic with occasional single-cycle resets.
        for (int k = 0; k < 3000; k++) begin
            ham_valid = ($urandom_range(0, 2) != 0);
            bch_valid = ($urandom_range(0, 2) != 0);
            ham_data  = HAM_N'($urandom);
            bch_data  = BCH_N'($urandom);
            rst_n     = ($urandom_range(0, 399) != 0);
            cyc();
        end
        rst_n = 1; ham_valid = 0; bch_valid = 0;
        repeat (70) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
